// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the accumulator-processor control unit:
//   - opcode values (OP_HLT .. OP_SUBI)
//   - ALU function codes (ALU_ADD, ALU_SUB)
//   - FSM state encoding (2-bit)
//   - accumulator input mux encodings (SELA_*)
//   - ctrl_t: the control vector produced by the decoder and held by the FSM
// -----------------------------------------------------------------------------
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;

    localparam logic [1:0] SELA_ALU = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_RAM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] sel_a;
        logic       sel_b;
        logic [5:0] alu_op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       halt;     // opcode is HLT; steers the FSM, not a port
    } ctrl_t;

    // Quiescent control vector: used at reset and in every non-EXEC cycle.
    localparam ctrl_t CTRL_IDLE = '{
        pc_en:  1'b0,
        sel_a:  SELA_ALU,
        sel_b:  1'b0,
        alu_op: ALU_ADD,
        wr_acc: 1'b0,
        wr_ram: 1'b0,
        rd_ram: 1'b0,
        halt:   1'b0
    };

endpackage

// File: rtl/bip_decoder.sv
// -----------------------------------------------------------------------------
// bip_decoder
// Purely combinational opcode decoder.
// Ports:
//   opcode  in  [bits_opcode-1:0]  opcode field of an instruction
//   ctrl    out ctrl_t             control vector for that opcode
// Unlisted opcodes decode as NOP (only pc_en set).
// -----------------------------------------------------------------------------
module bip_decoder
    import bip_pkg::*;
#(
    parameter int bits_opcode = 5
) (
    input  logic [bits_opcode-1:0] opcode,
    output ctrl_t                  ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves
        // a bit unassigned and no latch is inferred.
        ctrl       = CTRL_IDLE;
        ctrl.pc_en = 1'b1;
        case (opcode)
            bits_opcode'(OP_HLT): begin
                ctrl.pc_en = 1'b0;
                ctrl.halt  = 1'b1;
            end
            bits_opcode'(OP_STO): begin
                ctrl.wr_ram = 1'b1;
            end
            bits_opcode'(OP_LD): begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SELA_RAM;
                ctrl.wr_acc = 1'b1;
            end
            bits_opcode'(OP_LDI): begin
                ctrl.sel_a  = SELA_IMM;
                ctrl.wr_acc = 1'b1;
            end
            bits_opcode'(OP_ADD), bits_opcode'(OP_SUB): begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_b  = 1'b0;
                ctrl.sel_a  = SELA_ALU;
                ctrl.wr_acc = 1'b1;
                ctrl.alu_op = (opcode == bits_opcode'(OP_SUB)) ? ALU_SUB : ALU_ADD;
            end
            bits_opcode'(OP_ADDI), bits_opcode'(OP_SUBI): begin
                ctrl.sel_b  = 1'b1;
                ctrl.sel_a  = SELA_ALU;
                ctrl.wr_acc = 1'b1;
                ctrl.alu_op = (opcode == bits_opcode'(OP_SUBI)) ? ALU_SUB : ALU_ADD;
            end
            default: ;  // NOP
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
// Fetch/execute sequencer for the accumulator processor. Latches the fetched
// instruction, decodes it and drives registered datapath strobes for exactly
// one EXEC cycle per instruction (2 cycles per instruction).
// Optional build macro: BIP_CYCLE_COUNTER_EN adds cycle_count (CPI measurement).
// Ports:
//   clk          in   system clock (posedge)
//   rst          in   synchronous, active-high reset
//   run          in   start/continue execution
//   instr        in   instruction memory read data
//   pc_en        out  PC increment pulse
//   operand      out  latched immediate / data address
//   sel_a        out  accumulator input mux (ALU / imm / RAM)
//   sel_b        out  ALU B mux (RAM / imm)
//   alu_op       out  ALU function code
//   wr_acc       out  accumulator write strobe
//   wr_ram       out  data RAM write strobe
//   rd_ram       out  data RAM read enable
//   halted       out  FSM is in HALT
//   cycle_count  out  [31:0] FETCH+EXEC cycles since reset (macro only)
// -----------------------------------------------------------------------------
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int bits_address = 11,
    parameter int bits_opcode  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic [bits_opcode+bits_address-1:0] instr,
    output logic                            pc_en,
    output logic [bits_address-1:0]         operand,
    output logic [1:0]                      sel_a,
    output logic                            sel_b,
    output logic [5:0]                      alu_op,
    output logic                            wr_acc,
    output logic                            wr_ram,
    output logic                            rd_ram,
    output logic                            halted
`ifdef BIP_CYCLE_COUNTER_EN
    ,
    output logic [31:0]                     cycle_count
`endif
);

    state_t                  state, next_state;
    ctrl_t                   dec_ctrl, ctrl_d, ctrl_q;
    logic [bits_address-1:0] ir_operand;

    // Decode straight from the memory bus during FETCH so the registered
    // strobes are already valid in the EXEC cycle.
    bip_decoder #(
        .bits_opcode (bits_opcode)
    ) u_decoder (
        .opcode (instr[bits_opcode+bits_address-1:bits_address]),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        next_state = state;
        ctrl_d     = CTRL_IDLE;
        case (state)
            ST_IDLE:  next_state = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                next_state = ST_EXEC;
                ctrl_d     = dec_ctrl;
            end
            // The instruction always completes; run only picks what follows.
            ST_EXEC: begin
                if (ctrl_q.halt) next_state = ST_HALT;
                else             next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ST_IDLE;
            ctrl_q     <= CTRL_IDLE;
            ir_operand <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= ctrl_d;
            if (state == ST_FETCH) ir_operand <= instr[bits_address-1:0];
        end
    end

    assign pc_en   = ctrl_q.pc_en;
    assign sel_a   = ctrl_q.sel_a;
    assign sel_b   = ctrl_q.sel_b;
    assign alu_op  = ctrl_q.alu_op;
    assign wr_acc  = ctrl_q.wr_acc;
    assign wr_ram  = ctrl_q.wr_ram;
    assign rd_ram  = ctrl_q.rd_ram;
    assign operand = ir_operand;
    assign halted  = (state == ST_HALT);

`ifdef BIP_CYCLE_COUNTER_EN
    // Counts only active sequencing cycles; frozen in IDLE and HALT.
    always_ff @(posedge clk) begin
        if (rst)                                          cycle_count <= '0;
        else if (state == ST_FETCH || state == ST_EXEC)   cycle_count <= cycle_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_control_unit
// Table-driven cycle vectors for bip_control_unit plus hand-written sequences
// for HALT hold and reset during EXEC. Each vector applies inputs, advances
// one clock and compares the full output set 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_bip_control_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] instr;
    logic        pc_en;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [5:0]  alu_op;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic        halted;
`ifdef BIP_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
`endif

    int passed = 0;
    int total  = 0;

    bip_control_unit #(
        .bits_address (11),
        .bits_opcode  (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .instr   (instr),
        .pc_en   (pc_en),
        .operand (operand),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .alu_op  (alu_op),
        .wr_acc  (wr_acc),
        .wr_ram  (wr_ram),
        .rd_ram  (rd_ram),
        .halted  (halted)
`ifdef BIP_CYCLE_COUNTER_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, operand, sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, halted}
    logic [24:0] obs;
    assign obs = {pc_en, operand, sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, halted};

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] instr;
        logic [24:0] exp;
    } vec_t;

    function automatic logic [24:0] ex(input logic p, input logic [10:0] op,
                                       input logic [1:0] sa, input logic sb,
                                       input logic [5:0] alu, input logic wa,
                                       input logic wr, input logic rd,
                                       input logic h);
        return {p, op, sa, sb, alu, wa, wr, rd, h};
    endfunction

    function automatic logic [24:0] idle(input logic [10:0] op, input logic h);
        return ex(1'b0, op, 2'd0, 1'b0, 6'b100000, 1'b0, 1'b0, 1'b0, h);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else             passed++;
    endtask

    task automatic tick(input logic r, input logic rn, input logic [15:0] i);
        rst   = r;
        run   = rn;
        instr = i;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        rst = 1'b1; run = 1'b0; instr = 16'h0000;

        // Row semantics: inputs held during the cycle, exp = outputs after the edge.
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, idle(11'd0, 1'b0)};                    // reset
        vecs[1]  = '{1'b0, 1'b1, 16'h1805, idle(11'd0, 1'b0)};                    // IDLE->FETCH
        vecs[2]  = '{1'b0, 1'b1, 16'h1805, ex(1, 11'd5, 2'd1, 0, 6'h20, 1, 0, 0, 0)}; // LDI 5
        vecs[3]  = '{1'b0, 1'b1, 16'hFFFF, idle(11'd5, 1'b0)};                    // EXEC->FETCH
        vecs[4]  = '{1'b0, 1'b1, 16'h2803, ex(1, 11'd3, 2'd0, 1, 6'h20, 1, 0, 0, 0)}; // ADDI 3
        vecs[5]  = '{1'b0, 1'b1, 16'hFFFF, idle(11'd3, 1'b0)};
        vecs[6]  = '{1'b0, 1'b1, 16'h080A, ex(1, 11'd10, 2'd0, 0, 6'h20, 0, 1, 0, 0)}; // STO 10
        vecs[7]  = '{1'b0, 1'b1, 16'hFFFF, idle(11'd10, 1'b0)};
        vecs[8]  = '{1'b0, 1'b1, 16'h3007, ex(1, 11'd7, 2'd0, 0, 6'h22, 1, 0, 1, 0)};  // SUB 7
        vecs[9]  = '{1'b0, 1'b1, 16'hFFFF, idle(11'd7, 1'b0)};
        vecs[10] = '{1'b0, 1'b1, 16'h1004, ex(1, 11'd4, 2'd2, 0, 6'h20, 1, 0, 1, 0)};  // LD 4
        vecs[11] = '{1'b0, 1'b0, 16'hFFFF, idle(11'd4, 1'b0)};                    // run dropped in EXEC
        vecs[12] = '{1'b0, 1'b0, 16'h1805, idle(11'd4, 1'b0)};                    // stays IDLE
        vecs[13] = '{1'b0, 1'b0, 16'h1805, idle(11'd4, 1'b0)};
        vecs[14] = '{1'b0, 1'b1, 16'hF812, idle(11'd4, 1'b0)};                    // resume: FETCH
        vecs[15] = '{1'b0, 1'b1, 16'hF812, ex(1, 11'h012, 2'd0, 0, 6'h20, 0, 0, 0, 0)}; // NOP
        vecs[16] = '{1'b0, 1'b1, 16'hFFFF, idle(11'h012, 1'b0)};
        vecs[17] = '{1'b0, 1'b1, 16'h0000, idle(11'd0, 1'b0)};                    // HLT in EXEC
        vecs[18] = '{1'b0, 1'b1, 16'h1805, idle(11'd0, 1'b1)};                    // now HALT

        for (int i = 0; i < 19; i++) begin
            tick(vecs[i].rst, vecs[i].run, vecs[i].instr);
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
`ifdef BIP_CYCLE_COUNTER_EN
            if (i == 0) check("count_after_rst", cycle_count, 32'd0);
`endif
        end

        // HALT ignores run; pc_en stays low.
`ifdef BIP_CYCLE_COUNTER_EN
        begin
            logic [31:0] frozen;
            frozen = cycle_count;
            for (int c = 0; c < 20; c++) begin
                tick(1'b0, 1'b1, 16'h1805);
                check($sformatf("halt_hold%0d", c), 32'({pc_en, halted}), 32'b01);
            end
            check("count_frozen_in_halt", cycle_count, frozen);
        end
`else
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b1, 16'h1805);
            check($sformatf("halt_hold%0d", c), 32'({pc_en, halted}), 32'b01);
        end
`endif
        tick(1'b1, 1'b1, 16'h1805);
        check("halt_rst", 32'(obs), 32'(idle(11'd0, 1'b0)));
        tick(1'b0, 1'b0, 16'h1805);
        check("idle_after_halt_rst", 32'(obs), 32'(idle(11'd0, 1'b0)));

        // Reset during EXEC of STO: the write is seen once, never repeated.
        tick(1'b0, 1'b1, 16'h080A);
        check("sto_fetch", 32'(obs), 32'(idle(11'd0, 1'b0)));
        tick(1'b0, 1'b1, 16'h080A);
        check("sto_exec", 32'(obs), 32'(ex(1, 11'd10, 2'd0, 0, 6'h20, 0, 1, 0, 0)));
        tick(1'b1, 1'b1, 16'h080A);
        check("sto_rst", 32'(obs), 32'(idle(11'd0, 1'b0)));
`ifdef BIP_CYCLE_COUNTER_EN
        check("count_zero_after_rst", cycle_count, 32'd0);
`endif
        tick(1'b0, 1'b0, 16'h080A);
        check("sto_no_second_write", 32'(obs), 32'(idle(11'd0, 1'b0)));

        // Three instructions back to back, then stop.
        tick(1'b0, 1'b1, 16'h1805);
        tick(1'b0, 1'b1, 16'h1805);
        check("prog_ldi", 32'({pc_en, wr_acc, sel_a}), 32'b1101);
        tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b0, 1'b1, 16'h2803);
        check("prog_addi", 32'({pc_en, sel_b, alu_op}), 32'({1'b1, 1'b1, 6'b100000}));
        tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b0, 1'b1, 16'h080A);
        check("prog_sto", 32'({wr_ram, operand}), 32'({1'b1, 11'd10}));
        tick(1'b0, 1'b0, 16'hFFFF);
        check("prog_idle", 32'(obs), 32'(idle(11'd10, 1'b0)));
`ifdef BIP_CYCLE_COUNTER_EN
        check("count_three_instr", cycle_count, 32'd6);
        tick(1'b0, 1'b0, 16'hFFFF);
        check("count_frozen_idle", cycle_count, 32'd6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
